alu_result_stage: RTL and testbench

Downstream stage of the ALU. It captures each 64-bit ALU result (Rc) with its 5-bit opcode into a small in-order buffer and presents the oldest entry as the Z register (ZHi/ZLo) to the datapath bus. On retirement of MUL/DIV entries it updates the architectural HI/LO registers. It decouples the ALU issue cycle from the control unit's bus-read cycle through a valid/ready handshake on both sides.

---
 rtl/cpu_pkg.sv | 26 ++
 rtl/alu_result_stage_fifo.sv | 71 +++++++
 rtl/alu_result_stage.sv | 81 ++++++++
 tb/tb_alu_result_stage.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU opcodes and the result-buffer entry layout.
package cpu_pkg;

  localparam logic [4:0] OP_ADD = 5'b00011;
  localparam logic [4:0] OP_SUB = 5'b00100;
  localparam logic [4:0] OP_AND = 5'b01010;
  localparam logic [4:0] OP_OR  = 5'b01011;
  localparam logic [4:0] OP_MUL = 5'b01111;
  localparam logic [4:0] OP_DIV = 5'b10000;
  localparam logic [4:0] OP_NEG = 5'b10001;
  localparam logic [4:0] OP_NOT = 5'b10010;

  typedef struct packed {
    logic [63:0] rc;
    logic [4:0]  opcode;
    logic        zero;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

  // MUL and DIV are the only operations that produce an architectural HI/LO pair.
  function automatic logic writesHiLo(input logic [4:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/alu_result_stage_fifo.sv
// In-order circular buffer of ALU result entries with valid/ready on both sides.
module result_fifo
  import cpu_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               push_valid,
  output logic               push_ready,
  input  logic [ENTRY_W-1:0] push_data,
  output logic               pop_valid,
  input  logic               pop_ready,
  output logic [ENTRY_W-1:0] head_data,
  output logic [CW-1:0]      count
);

  localparam int            PW   = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]      head_q, head_d;
  logic [PW-1:0]      tail_q, tail_d;
  logic [CW-1:0]      count_q, count_d;
  logic               push;
  logic               pop;

  // No pass-through when full: acceptance depends only on stored occupancy.
  assign push_ready = (count_q < FULL);
  assign pop_valid  = (count_q != '0);
  assign push       = push_valid && push_ready && !flush;
  assign pop        = pop_valid && pop_ready && !flush;
  assign head_data  = mem_q[head_q];
  assign count      = count_q;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) tail_d = tail_q + PW'(1);
      if (pop)  head_d = head_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (push) mem_q[tail_q] <= push_data;
    end
  end

endmodule

// File: rtl/alu_result_stage.sv
// ALU result stage: buffers results, presents the oldest as Z, and retires MUL/DIV into HI/LO.
module alu_result_stage
  import cpu_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [63:0]   in_rc,
  input  logic [4:0]    in_opcode,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_zhi,
  output logic [31:0]   out_zlo,
  output logic [4:0]    out_opcode,
  output logic          out_zero,
  input  logic          flush,
  input  logic [31:0]   bus_in,
  input  logic          hi_wr,
  input  logic          lo_wr,
  output logic [31:0]   hi_q,
  output logic [31:0]   lo_q,
  output logic [CW-1:0] count
);

  entry_t      inEntry;
  entry_t      headEntry;
  logic        retireHiLo;
  logic [31:0] hi_d;
  logic [31:0] lo_d;

  assign inEntry.rc     = in_rc;
  assign inEntry.opcode = in_opcode;
  assign inEntry.zero   = (in_rc[31:0] == 32'd0);

  result_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .push_valid (in_valid),
    .push_ready (in_ready),
    .push_data  (inEntry),
    .pop_valid  (out_valid),
    .pop_ready  (out_ready),
    .head_data  (headEntry),
    .count      (count)
  );

  assign out_zhi    = headEntry.rc[63:32];
  assign out_zlo    = headEntry.rc[31:0];
  assign out_opcode = headEntry.opcode;
  assign out_zero   = headEntry.zero;

  // A bus write is younger than the retiring entry, so it overrides that register only.
  assign retireHiLo = out_valid && out_ready && !flush && writesHiLo(headEntry.opcode);

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (retireHiLo) begin
      hi_d = headEntry.rc[63:32];
      lo_d = headEntry.rc[31:0];
    end
    if (hi_wr) hi_d = bus_in;
    if (lo_wr) lo_d = bus_in;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: directed scenarios plus randomized traffic against a queue model.
module tb_alu_result_stage;

  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH + 1);

  localparam logic [4:0] C_ADD = 5'b00011;
  localparam logic [4:0] C_SUB = 5'b00100;
  localparam logic [4:0] C_AND = 5'b01010;
  localparam logic [4:0] C_OR  = 5'b01011;
  localparam logic [4:0] C_MUL = 5'b01111;
  localparam logic [4:0] C_DIV = 5'b10000;
  localparam logic [4:0] C_NEG = 5'b10001;
  localparam logic [4:0] C_NOT = 5'b10010;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [63:0]   in_rc;
  logic [4:0]    in_opcode;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_zhi;
  logic [31:0]   out_zlo;
  logic [4:0]    out_opcode;
  logic          out_zero;
  logic          flush;
  logic [31:0]   bus_in;
  logic          hi_wr;
  logic          lo_wr;
  logic [31:0]   hi_q;
  logic [31:0]   lo_q;
  logic [CW-1:0] count;

  int nChecks = 0;
  int nPassed = 0;

  typedef struct {
    logic [63:0] rc;
    logic [4:0]  op;
  } ment_t;

  ment_t       mq[$];
  logic [31:0] mHi = '0;
  logic [31:0] mLo = '0;

  alu_result_stage #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_rc(in_rc), .in_opcode(in_opcode), .out_valid(out_valid), .out_ready(out_ready),
    .out_zhi(out_zhi), .out_zlo(out_zlo), .out_opcode(out_opcode), .out_zero(out_zero),
    .flush(flush), .bus_in(bus_in), .hi_wr(hi_wr), .lo_wr(lo_wr),
    .hi_q(hi_q), .lo_q(lo_q), .count(count)
  );

  always #5 clk = ~clk;

  task automatic idle();
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    hi_wr     = 1'b0;
    lo_wr     = 1'b0;
    in_rc     = '0;
    in_opcode = '0;
    bus_in    = '0;
  endtask

  task automatic pushOp(input logic [4:0] op, input logic [63:0] rc);
    in_valid  = 1'b1;
    in_opcode = op;
    in_rc     = rc;
  endtask

  // Advance the reference model by one clock from the currently driven inputs, then clock the DUT.
  task automatic tick();
    ment_t e;
    logic  doPush;
    logic  doPop;
    doPush = in_valid && (mq.size() < DEPTH) && !flush;
    doPop  = (mq.size() > 0) && out_ready && !flush;
    if (!reset) begin
      mq.delete();
      mHi = '0;
      mLo = '0;
    end else begin
      if (doPop) begin
        e = mq.pop_front();
        if (e.op == C_MUL || e.op == C_DIV) begin
          mHi = e.rc[63:32];
          mLo = e.rc[31:0];
        end
      end
      if (hi_wr) mHi = bus_in;
      if (lo_wr) mLo = bus_in;
      if (flush) mq.delete();
      if (doPush) begin
        e.rc = in_rc;
        e.op = in_opcode;
        mq.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b0;
    tick();
    tick();
    idle();
    tick();
    nChecks++; if (count !== 2'd0) $display("[TB] FAIL reset_count: got %0d expected 0", count); else nPassed++;
    nChecks++; if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); else nPassed++;
    nChecks++; if (in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); else nPassed++;
    nChecks++; if (hi_q !== 32'd0 || lo_q !== 32'd0) $display("[TB] FAIL reset_hilo: got %h/%h expected 0/0", hi_q, lo_q); else nPassed++;
    nChecks++; if ({out_zhi, out_zlo, out_opcode, out_zero} !== 70'd0) $display("[TB] FAIL reset_head: got %h %h %h %b expected all 0", out_zhi, out_zlo, out_opcode, out_zero); else nPassed++;
  endtask

  task automatic test_push_add();
    idle();
    pushOp(C_ADD, 64'h0000_0000_0000_0005);
    tick();
    idle();
    nChecks++; if (out_valid !== 1'b1) $display("[TB] FAIL add_valid: got %b expected 1", out_valid); else nPassed++;
    nChecks++; if (out_zlo !== 32'd5 || out_zhi !== 32'd0) $display("[TB] FAIL add_z: got %h_%h expected 0_5", out_zhi, out_zlo); else nPassed++;
    nChecks++; if (out_zero !== 1'b0 || out_opcode !== C_ADD) $display("[TB] FAIL add_flags: got zero=%b op=%h expected zero=0 op=%h", out_zero, out_opcode, C_ADD); else nPassed++;
    out_ready = 1'b1;
    tick();
    idle();
    nChecks++; if (count !== 2'd0 || hi_q !== 32'd0 || lo_q !== 32'd0) $display("[TB] FAIL add_retire: got count=%0d hi=%h lo=%h expected 0/0/0", count, hi_q, lo_q); else nPassed++;
  endtask

  task automatic test_mul_retire();
    idle();
    pushOp(C_MUL, 64'h0000_0001_8000_0000);
    tick();
    pushOp(C_OR, 64'h0);
    out_ready = 1'b1;
    tick();
    idle();
    nChecks++; if (hi_q !== 32'h1 || lo_q !== 32'h8000_0000) $display("[TB] FAIL mul_hilo: got %h/%h expected 00000001/80000000", hi_q, lo_q); else nPassed++;
    nChecks++; if (count !== 2'd1 || out_opcode !== C_OR || out_zero !== 1'b1) $display("[TB] FAIL or_head: got count=%0d op=%h zero=%b expected 1/%h/1", count, out_opcode, out_zero, C_OR); else nPassed++;
    out_ready = 1'b1;
    tick();
    idle();
    nChecks++; if (hi_q !== 32'h1 || lo_q !== 32'h8000_0000 || count !== 2'd0) $display("[TB] FAIL or_retire: got %h/%h count=%0d expected unchanged, count 0", hi_q, lo_q, count); else nPassed++;
  endtask

  task automatic test_fill();
    idle();
    pushOp(C_ADD, 64'h11);
    tick();
    pushOp(C_SUB, 64'h22);
    tick();
    nChecks++; if (in_ready !== 1'b0 || count !== 2'd2) $display("[TB] FAIL fill_full: got ready=%b count=%0d expected 0/2", in_ready, count); else nPassed++;
    pushOp(C_AND, 64'h33);
    tick();
    nChecks++; if (count !== 2'd2 || out_zlo !== 32'h11) $display("[TB] FAIL fill_ignore: got count=%0d head=%h expected 2/11", count, out_zlo); else nPassed++;
    idle();
    out_ready = 1'b1;
    tick();
    idle();
    nChecks++; if (in_ready !== 1'b1 || count !== 2'd1) $display("[TB] FAIL fill_pop: got ready=%b count=%0d expected 1/1", in_ready, count); else nPassed++;
    nChecks++; if (out_zlo !== 32'h22 || out_opcode !== C_SUB) $display("[TB] FAIL fill_order: got %h op=%h expected 22/%h", out_zlo, out_opcode, C_SUB); else nPassed++;
    out_ready = 1'b1;
    tick();
    idle();
  endtask

  task automatic test_div_buswrite();
    idle();
    pushOp(C_DIV, {32'h3, 32'h7});
    tick();
    idle();
    out_ready = 1'b1;
    hi_wr     = 1'b1;
    bus_in    = 32'hAA;
    tick();
    idle();
    nChecks++; if (hi_q !== 32'hAA || lo_q !== 32'h7) $display("[TB] FAIL div_bus: got %h/%h expected 000000aa/00000007", hi_q, lo_q); else nPassed++;
    pushOp(C_MUL, {32'h55, 32'h66});
    tick();
    idle();
    out_ready = 1'b1;
    lo_wr     = 1'b1;
    bus_in    = 32'hBB;
    tick();
    idle();
    nChecks++; if (hi_q !== 32'h55 || lo_q !== 32'hBB) $display("[TB] FAIL mul_lobus: got %h/%h expected 00000055/000000bb", hi_q, lo_q); else nPassed++;
  endtask

  task automatic test_flush();
    idle();
    hi_wr  = 1'b1;
    bus_in = 32'h111;
    tick();
    idle();
    lo_wr  = 1'b1;
    bus_in = 32'h222;
    tick();
    idle();
    pushOp(C_MUL, {32'h5, 32'h6});
    tick();
    pushOp(C_ADD, 64'h9);
    tick();
    idle();
    nChecks++; if (count !== 2'd2) $display("[TB] FAIL flush_pre: got count=%0d expected 2", count); else nPassed++;
    flush     = 1'b1;
    out_ready = 1'b1;
    tick();
    idle();
    nChecks++; if (count !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) $display("[TB] FAIL flush_empty: got count=%0d valid=%b ready=%b expected 0/0/1", count, out_valid, in_ready); else nPassed++;
    nChecks++; if (hi_q !== 32'h111 || lo_q !== 32'h222) $display("[TB] FAIL flush_hilo: got %h/%h expected 00000111/00000222", hi_q, lo_q); else nPassed++;
    flush  = 1'b1;
    hi_wr  = 1'b1;
    bus_in = 32'h333;
    pushOp(C_ADD, 64'h1);
    tick();
    idle();
    nChecks++; if (hi_q !== 32'h333 || count !== 2'd0) $display("[TB] FAIL flush_buswr: got hi=%h count=%0d expected 00000333/0", hi_q, count); else nPassed++;
  endtask

  task automatic test_reset_midstream();
    idle();
    pushOp(C_ADD, 64'h7);
    tick();
    pushOp(C_MUL, {32'h1, 32'h2});
    out_ready = 1'b1;
    hi_wr     = 1'b1;
    bus_in    = 32'h44;
    flush     = 1'b1;
    reset     = 1'b0;
    tick();
    idle();
    nChecks++; if (count !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) $display("[TB] FAIL midrst_ctl: got count=%0d valid=%b ready=%b expected 0/0/1", count, out_valid, in_ready); else nPassed++;
    nChecks++; if (hi_q !== 32'd0 || lo_q !== 32'd0) $display("[TB] FAIL midrst_hilo: got %h/%h expected 0/0", hi_q, lo_q); else nPassed++;
    nChecks++; if ({out_zhi, out_zlo, out_opcode, out_zero} !== 70'd0) $display("[TB] FAIL midrst_head: got %h %h %h %b expected all 0", out_zhi, out_zlo, out_opcode, out_zero); else nPassed++;
  endtask

  task automatic test_random();
    logic [4:0] ops [8];
    ops = '{C_ADD, C_SUB, C_AND, C_OR, C_MUL, C_DIV, C_NEG, C_NOT};
    for (int cyc = 0; cyc < 400; cyc++) begin
      nChecks++; if (count !== CW'(mq.size())) $display("[TB] FAIL rnd_count c%0d: got %0d expected %0d", cyc, count, mq.size()); else nPassed++;
      nChecks++; if (out_valid !== (mq.size() != 0) || in_ready !== (mq.size() < DEPTH)) $display("[TB] FAIL rnd_hs c%0d: got valid=%b ready=%b for occupancy %0d", cyc, out_valid, in_ready, mq.size()); else nPassed++;
      nChecks++; if (hi_q !== mHi || lo_q !== mLo) $display("[TB] FAIL rnd_hilo c%0d: got %h/%h expected %h/%h", cyc, hi_q, lo_q, mHi, mLo); else nPassed++;
      if (mq.size() != 0) begin
        nChecks++;
        if (out_zhi !== mq[0].rc[63:32] || out_zlo !== mq[0].rc[31:0] || out_opcode !== mq[0].op || out_zero !== (mq[0].rc[31:0] == 32'd0))
          $display("[TB] FAIL rnd_head c%0d: got %h_%h op=%h z=%b expected %h op=%h", cyc, out_zhi, out_zlo, out_opcode, out_zero, mq[0].rc, mq[0].op);
        else nPassed++;
      end
      reset     = ($urandom_range(0, 99) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      hi_wr     = ($urandom_range(0, 9) == 0);
      lo_wr     = ($urandom_range(0, 9) == 0);
      bus_in    = $urandom;
      in_valid  = $urandom_range(0, 1);
      out_ready = $urandom_range(0, 1);
      in_opcode = ops[$urandom_range(0, 7)];
      in_rc     = {$urandom, ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom)};
      tick();
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_push_add();
    test_mul_retire();
    test_fill();
    test_div_buswrite();
    test_flush();
    test_reset_midstream();
    test_random();
    $display("%0d/%0d checks passed", nPassed, nChecks);
    $finish;
  end

endmodule
